axi4_lite_read_slave: RTL

Parametrised AXI4-Lite read-channel slave. It accepts AR requests into a small address FIFO and decodes each into a register index. It fetches data from an external register bank over a request/valid port and returns R beats with proper OKAY/SLVERR/DECERR responses. It sits between the AXI4-Lite interconnect and a peripheral register bank, and replaces single-outstanding, always-OKAY read logic.

---
 rtl/axi4_lite_read_slave.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-channel slave.
// AR requests are queued in a small address FIFO and served one at a time.
// In-range requests fetch data from an external register bank over a
// request/valid port. Out-of-range requests answer DECERR without touching
// the bank, and a bank that never answers is cut off with SLVERR after
// TIMEOUT_CYCLES wait cycles. R beats leave in AR acceptance order.
module axi4_lite_read_slave #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int NUM_REGS       = 16,
    parameter int AR_FIFO_DEPTH  = 2,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     axi_clk,
    input  logic                     resetn,
    input  logic [ADDRESS_WIDTH-1:0] read_addr,
    input  logic                     read_addr_valid,
    output logic                     read_addr_ready,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic [1:0]               read_resp,
    output logic                     read_data_valid,
    input  logic                     read_data_ready,
    output logic                     reg_rd_en,
    output logic [IDX_W-1:0]         reg_rd_index,
    input  logic [DATA_WIDTH-1:0]    reg_rd_data,
    input  logic                     reg_rd_valid,
    output logic                     busy
);

    // Byte-lane bits below LSB are dropped by the word decode
    localparam int LSB     = $clog2(DATA_WIDTH / 8);
    localparam int FULL_W  = ADDRESS_WIDTH - LSB;
    localparam int PTR_W   = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(AR_FIFO_DEPTH + 1);
    localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [FULL_W:0]  NUM_REGS_L  = (FULL_W + 1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] DEPTH_L     = CNT_W'(AR_FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST_L  = PTR_W'(AR_FIFO_DEPTH - 1);
    localparam logic [TO_W-1:0]  TO_LAST_L   = TO_W'(TO_LAST);
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [1:0]       RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Circular pointer advance that also works for non-power-of-two wrap points
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] v;
        if (p == PTR_LAST_L) begin
            v = '0;
        end else begin
            v = p + PTR_W'(1);
        end
        return v;
    endfunction

    // FIFO storage holds only the word index; byte-lane bits are never needed
    logic [FULL_W-1:0]     r_mem [AR_FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic [FULL_W-1:0]     w_head_idx;
    logic                  w_head_oor;
    logic                  w_unused_lsb;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TO_W-1:0]       r_to_cnt;
    logic [TO_W-1:0]       w_to_nxt;
    logic                  w_timeout;

    logic                  r_ar_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [1:0]            r_resp;
    logic [1:0]            w_resp_nxt;
    logic                  r_rvalid;
    logic                  r_rd_en;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  r_busy;

    assign w_unused_lsb = ^read_addr[LSB-1:0];

    assign w_push     = read_addr_valid & r_ar_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_head_idx = r_mem[r_rd_ptr];
    assign w_head_oor = ({1'b0, w_head_idx} >= NUM_REGS_L);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_to_cnt == TO_LAST_L);

    // Occupancy for the next cycle; a simultaneous push and pop cancel out
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Address FIFO storage and pointers
    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < AR_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= read_addr[ADDRESS_WIDTH-1:LSB];
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; reg_rd_valid only matters in WAIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = w_head_oor ? S_RESP : S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (reg_rd_valid || w_timeout) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (read_data_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the response, index and timeout registers
    always_comb begin
        w_data_nxt = r_data;
        w_resp_nxt = r_resp;
        w_idx_nxt  = r_idx;
        w_to_nxt   = r_to_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pop && w_head_oor) begin
                    w_data_nxt = '0;
                    w_resp_nxt = RESP_DECERR;
                end else if (w_pop) begin
                    w_idx_nxt = w_head_idx[IDX_W-1:0];
                end else begin
                    w_idx_nxt = r_idx;
                end
            end
            S_ISSUE: begin
                w_to_nxt = '0;
            end
            S_WAIT: begin
                if (reg_rd_valid) begin
                    w_data_nxt = reg_rd_data;
                    w_resp_nxt = RESP_OKAY;
                end else if (w_timeout) begin
                    w_data_nxt = '0;
                    w_resp_nxt = RESP_SLVERR;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_RESP: begin
                w_data_nxt = r_data;
                w_resp_nxt = r_resp;
            end
            default: begin
                w_to_nxt = '0;
            end
        endcase
    end

    // Registered outputs, derived from next state so they line up with it
    always_ff @(posedge axi_clk or negedge resetn) begin
        if (!resetn) begin
            r_ar_ready <= 1'b0;
            r_data     <= '0;
            r_resp     <= 2'b00;
            r_rvalid   <= 1'b0;
            r_rd_en    <= 1'b0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_ar_ready <= (w_count_nxt < DEPTH_L);
            r_data     <= w_data_nxt;
            r_resp     <= w_resp_nxt;
            r_rvalid   <= (w_state_nxt == S_RESP);
            r_rd_en    <= (w_state_nxt == S_ISSUE);
            r_idx      <= w_idx_nxt;
            r_busy     <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
            r_to_cnt   <= w_to_nxt;
        end
    end

    assign read_addr_ready = r_ar_ready;
    assign read_data       = r_data;
    assign read_resp       = r_resp;
    assign read_data_valid = r_rvalid;
    assign reg_rd_en       = r_rd_en;
    assign reg_rd_index    = r_idx;
    assign busy            = r_busy;

endmodule
